// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RISC-V instruction-fetch stage (PC, request FIFO, instruction buffer)
//
// Purpose:
//   Owns the program counter and issues word fetches to instruction memory
//   over a request/grant interface with in-order responses. It buffers the
//   returned words and presents {PC, instruction} pairs to the IF/ID
//   register. That register's write enable is the consume strobe. A redirect
//   from EX flushes buffered words and discards every response still in
//   flight.
//
// Configuration macro:
//   IF_PREFETCH_EN : defined -> CAP=2 (two outstanding requests, 2-entry buffer,
//                    full-rate fetch); undefined -> CAP=1 (half-rate fetch).
//
// Ports:
//   clk             in   clock, all state on posedge
//   res             in   synchronous active-low reset
//   write           in   IF/ID accepts the presented pair this cycle
//   redirect        in   taken branch/jump from EX
//   redirect_pc     in   redirect target (bits [1:0] ignored)
//   imem_req        out  fetch request valid
//   imem_addr       out  fetch word address (= pc_q)
//   imem_gnt        in   memory accepts the request
//   imem_rvalid     in   response word valid (in order)
//   imem_rdata      in   response word
//   PC_out          out  PC of presented instruction (0 when none)
//   INSTRUCTION_out out  presented instruction (NOP_INSTR when none)
//   instr_valid     out  presented pair is valid

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        res,
  input  logic        write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] INSTRUCTION_out,
  output logic        instr_valid
);

`ifdef IF_PREFETCH_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  localparam logic [2:0] CAP3 = 3'(CAP);

  // FIFO pointers are one bit wide; with CAP=1 they stay at zero.
  function automatic logic ptr_next(input logic p);
    return (CAP == 1) ? 1'b0 : ~p;
  endfunction

  // Control state
  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;
  logic [1:0]  count_q, count_d;
  logic        awr_q, awr_d;
  logic        ard_q, ard_d;
  logic        bwr_q, bwr_d;
  logic        brd_q, brd_d;

  // Storage: address FIFO of outstanding PCs, instruction buffer of {pc, word}
  logic [31:0] apc_q   [CAP];
  logic [31:0] bpc_q   [CAP];
  logic [31:0] bword_q [CAP];

  logic        pop;
  logic        rsp_ok;
  logic        rsp_drop;
  logic        push;
  logic        grant;
  logic [2:0]  committed;

  // Low address bits of the redirect target are discarded on purpose.
  logic        unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Handshake and request qualification
  always_comb begin
    instr_valid = (count_q != 2'd0);
    pop         = instr_valid & write;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok      = imem_rvalid & (outst_q != 2'd0);
    rsp_drop    = rsp_ok & (drop_q != 2'd0);
    push        = rsp_ok & ~rsp_drop;
    // Slots already claimed by in-flight requests and buffered words, crediting
    // the entry IF/ID consumes this cycle so a pop can free room immediately.
    committed   = {1'b0, outst_q} + {1'b0, count_q} - {2'b00, pop};
    imem_req    = res & ~redirect & (committed < CAP3);
    grant       = imem_req & imem_gnt;
  end

  assign imem_addr       = pc_q;
  assign PC_out          = instr_valid ? bpc_q[brd_q]   : 32'h0000_0000;
  assign INSTRUCTION_out = instr_valid ? bword_q[brd_q] : NOP_INSTR;

  // Next-state
  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    count_d = count_q;
    awr_d   = awr_q;
    ard_d   = ard_q;
    bwr_d   = bwr_q;
    brd_d   = brd_q;

    if (grant) begin
      pc_d  = pc_q + 32'd4;
      awr_d = ptr_next(awr_q);
    end

    outst_d = outst_q + {1'b0, grant} - {1'b0, rsp_ok};

    if (rsp_ok) begin
      ard_d = ptr_next(ard_q);
    end
    if (rsp_drop) begin
      drop_d = drop_q - 2'd1;
    end

    if (push) begin
      bwr_d = ptr_next(bwr_q);
    end
    if (pop) begin
      brd_d = ptr_next(brd_q);
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    // Redirect wins: no grant can occur (imem_req is low), the buffer is
    // emptied, and every request still outstanding after this cycle's
    // response becomes a drop. A response arriving now is therefore never
    // buffered either.
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
      bwr_d   = 1'b0;
      brd_d   = 1'b0;
      drop_d  = outst_q - {1'b0, rsp_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      pc_q    <= RESET_PC;
      outst_q <= 2'd0;
      drop_q  <= 2'd0;
      count_q <= 2'd0;
      awr_q   <= 1'b0;
      ard_q   <= 1'b0;
      bwr_q   <= 1'b0;
      brd_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      awr_q   <= awr_d;
      ard_q   <= ard_d;
      bwr_q   <= bwr_d;
      brd_q   <= brd_d;
    end
  end

  // Data storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (grant) begin
      apc_q[awr_q] <= pc_q;
    end
    if (push) begin
      bpc_q[bwr_q]   <= apc_q[ard_q];
      bword_q[bwr_q] <= imem_rdata;
    end
  end

endmodule
